fetch_queue_stage: RTL

Instruction-fetch stage of the RISC-V core, sitting directly upstream of `if_id_buffer`. It owns the program counter and drives the combinational `memoriainstrucciones` read port. Each fetched instruction is captured with its PC into a small queue and presented to decode under a valid/ready handshake. Branch redirects (e.g. taken `bne`) from the control path flush the queue and reload the PC.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/fetch_queue_stage.sv | 48 ++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, NOP encoding and fetch queue entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch entries with push, pop, flush and occupancy count
import riscv_pkg::*;
module fetch_fifo #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic [AW:0]  count
);
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  // next pointers, occupancy and storage; flush empties the buffer
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = wr_data;
    rd_d = flush ? '0 : rd_q + AW'(pop);
    wr_d = flush ? '0 : wr_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // entry storage needs no reset: contents are only visible while count is nonzero
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_data = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC ownership, instruction fetch and queued valid/ready hand-off to decode
import riscv_pkg::*;
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4
);
  localparam int AW = $clog2(FQ_DEPTH);
  logic [XLEN-1:0] pc_q, pc_d;
  logic push, pop;
  logic [AW:0] count;
  fetch_entry_t head;
  // handshake, push gating and next PC; a redirect wins and suppresses the push
  always_comb begin
    dec_valid = count != '0;
    pop = dec_valid & dec_ready;
    push = fetch_en & ~redirect_valid & ((count < (AW+1)'(FQ_DEPTH)) | pop);
    pc_d = redirect_valid ? (redirect_pc & ~32'h3) : push ? pc_q + 32'd4 : pc_q;
    dec_instr = dec_valid ? head.instr : RV_NOP;
    dec_pc = dec_valid ? head.pc : '0;
    dec_pc_plus4 = dec_pc + 32'd4;
  end
  // program counter register
  always_ff @(posedge clk) pc_q <= !rst_n ? RESET_PC : pc_d;
  assign imem_addr = pc_q;
  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .wr_data('{pc: pc_q, instr: imem_data}),
    .rd_data(head),
    .count(count)
  );
endmodule
